// File: rtl/wb_regfile.sv
// Writeback-side register file: 32 GPRs (r0 hardwired to zero) plus the HI/LO pair.
// Define WB_BYPASS_EN for same-cycle write-through on the GPR and HI/LO read ports.
module wb_regfile #(
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned DW      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DW-1:0]     wdata,
    input  logic              re1,
    input  logic [REG_AW-1:0] raddr1,
    output logic [DW-1:0]     rdata1,
    input  logic              re2,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DW-1:0]     rdata2,
    input  logic              hilo_we,
    input  logic [DW-1:0]     hi_i,
    input  logic [DW-1:0]     lo_i,
    output logic [DW-1:0]     hi_o,
    output logic [DW-1:0]     lo_o
);

    logic [DW-1:0] regs_q [REG_NUM];
    logic [DW-1:0] hi_q;
    logic [DW-1:0] lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (we && (waddr != '0)) begin
                regs_q[waddr] <= wdata;
            end
            if (hilo_we) begin
                hi_q <= hi_i;
                lo_q <= lo_i;
            end
        end
    end

    // raddr != 0 already implies waddr != 0 on a bypass hit.
    always_comb begin
        rdata1 = '0;
        if (rst || (raddr1 == '0)) begin
            rdata1 = '0;
`ifdef WB_BYPASS_EN
        end else if (we && re1 && (raddr1 == waddr)) begin
            rdata1 = wdata;
`endif
        end else if (re1) begin
            rdata1 = regs_q[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst || (raddr2 == '0)) begin
            rdata2 = '0;
`ifdef WB_BYPASS_EN
        end else if (we && re2 && (raddr2 == waddr)) begin
            rdata2 = wdata;
`endif
        end else if (re2) begin
            rdata2 = regs_q[raddr2];
        end
    end

    always_comb begin
        hi_o = hi_q;
        lo_o = lo_q;
`ifdef WB_BYPASS_EN
        if (hilo_we) begin
            hi_o = hi_i;
            lo_o = lo_i;
        end
`endif
        if (rst) begin
            hi_o = '0;
            lo_o = '0;
        end
    end

endmodule
